// File: rtl/pipemdu_pkg.sv
// pipemdu_pkg: shared definitions for the iterative multiply/divide unit.
//   - operation encodings carried on eop
//   - sequencer state encodings
//   - default operand width
package pipemdu_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mdu_step.sv
// mdu_step: one combinational radix-2 step of the multiply/divide loop.
// Ports:
//   acc      in  upper accumulator (mult) or partial remainder (div)
//   opq      in  shifting operand: multiplier (mult) or dividend/quotient (div)
//   opd      in  fixed operand: multiplicand (mult) or divisor (div)
//   is_div   in  1 selects the shift-subtract divide step
//   acc_next out accumulator/remainder after this step
//   opq_next out shifting operand after this step
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] opq,
  input  logic [WIDTH-1:0] opd,
  input  logic             is_div,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] opq_next
);

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  // The shifted remainder can carry into bit WIDTH, so the compare is done
  // one bit wider; the difference itself always fits in WIDTH bits.
  always_comb begin
    addend   = opq[0] ? opd : {WIDTH{1'b0}};
    sum      = {1'b0, acc} + {1'b0, addend};
    shifted  = {acc, opq[WIDTH-1]};
    diff     = shifted[WIDTH-1:0] - opd;
    acc_next = sum[WIDTH:1];
    opq_next = {sum[0], opq[WIDTH-1:1]};
    if (is_div) begin
      if (shifted >= {1'b0, opd}) begin
        acc_next = diff;
        opq_next = {opq[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = shifted[WIDTH-1:0];
        opq_next = {opq[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/pipemdu.sv
// pipemdu: iterative multiply/divide sequencer beside the EXE stage.
// Runs MULT/MULTU/DIV/DIVU as a 32-step loop on magnitudes, fixes signs in a
// final cycle and writes the architectural HI/LO registers.
// Ports:
//   clock, resetn        pipeline clock, asynchronous active-low reset
//   estart, eop, ea, eb  mult/div issue from EXE (op, rs, rt)
//   ewhi, ewlo           MTHI/MTLO in EXE (data on ea)
//   erdhilo              MFHI/MFLO in EXE
//   ecancel              squash of the instruction in EXE / running op
//   hi, lo               HI/LO registers
//   busy                 sequencer not idle
//   stall                freeze PC/IF/ID/EXE this cycle
//   done                 one-cycle pulse after HI/LO take a mult/div result
module pipemdu
  import pipemdu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             estart,
  input  logic [1:0]       eop,
  input  logic [WIDTH-1:0] ea,
  input  logic [WIDTH-1:0] eb,
  input  logic             ewhi,
  input  logic             ewlo,
  input  logic             erdhilo,
  input  logic             ecancel,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mdu_state_e       state, state_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc, opq, opd;
  logic             is_div, res_neg, rem_neg, div_zero;

  mdu_op_e          op;
  logic             op_signed, op_div, start_zero, start_ok;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH-1:0] acc_next, opq_next;
  logic [2*WIDTH-1:0] product, product_fix;
  logic [WIDTH-1:0] quot_fix, rem_fix, fix_hi, fix_lo;

  // Decode the issuing op and form operand magnitudes; unsigned ops keep
  // their raw values.
  always_comb begin
    op         = mdu_op_e'(eop);
    op_signed  = (op == OP_MULT) || (op == OP_DIV);
    op_div     = (op == OP_DIVU) || (op == OP_DIV);
    abs_a      = (op_signed && ea[WIDTH-1]) ? -ea : ea;
    abs_b      = (op_signed && eb[WIDTH-1]) ? -eb : eb;
    start_zero = op_div && (eb == '0);
    start_ok   = estart && !ecancel;
  end

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .opq      (opq),
    .opd      (opd),
    .is_div   (is_div),
    .acc_next (acc_next),
    .opq_next (opq_next)
  );

  // Sign correction of the magnitude results. For divide by zero the
  // remainder register holds |ea|, so applying the remainder sign restores
  // the original ea for HI.
  always_comb begin
    product     = {acc, opq};
    product_fix = res_neg ? -product : product;
    quot_fix    = res_neg ? -opq : opq;
    rem_fix     = rem_neg ? -acc : acc;
    if (is_div) begin
      fix_hi = rem_fix;
      fix_lo = div_zero ? {WIDTH{1'b1}} : quot_fix;
    end else begin
      fix_hi = product_fix[2*WIDTH-1:WIDTH];
      fix_lo = product_fix[WIDTH-1:0];
    end
  end

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_next;
  end

  // Next-state logic; ecancel always returns a busy sequencer to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start_ok) state_next = start_zero ? S_FIX : S_RUN;
      S_RUN: begin
        if (ecancel)             state_next = S_IDLE;
        else if (count == LAST)  state_next = S_FIX;
      end
      S_FIX:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, HI/LO writes and the done pulse.
  // MT writes are only taken in IDLE; while busy they are held by stall.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      hi       <= '0;
      lo       <= '0;
      count    <= '0;
      acc      <= '0;
      opq      <= '0;
      opd      <= '0;
      is_div   <= 1'b0;
      res_neg  <= 1'b0;
      rem_neg  <= 1'b0;
      div_zero <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            count    <= '0;
            is_div   <= op_div;
            div_zero <= start_zero;
            res_neg  <= op_signed && (ea[WIDTH-1] ^ eb[WIDTH-1]);
            rem_neg  <= op_signed && ea[WIDTH-1];
            if (start_zero) begin
              acc <= abs_a;
              opq <= '0;
              opd <= '0;
            end else if (op_div) begin
              acc <= '0;
              opq <= abs_a;
              opd <= abs_b;
            end else begin
              acc <= '0;
              opq <= abs_b;
              opd <= abs_a;
            end
          end else if (!ecancel) begin
            if (ewhi) hi <= ea;
            if (ewlo) lo <= ea;
          end
        end
        S_RUN: begin
          if (!ecancel) begin
            acc   <= acc_next;
            opq   <= opq_next;
            count <= count + 1'b1;
          end
        end
        S_FIX: begin
          if (!ecancel) begin
            hi   <= fix_hi;
            lo   <= fix_lo;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy  = (state != S_IDLE);
  assign stall = busy && (estart || erdhilo || ewhi || ewlo);

endmodule

// File: tb/tb_pipemdu.sv
// tb_pipemdu: self-checking bench for pipemdu. Expected HI/LO come from a
// 64-bit arithmetic model of the multiply/divide rules.
module tb_pipemdu;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        estart = 1'b0;
  logic [1:0]  eop = 2'b00;
  logic [31:0] ea = '0;
  logic [31:0] eb = '0;
  logic        ewhi = 1'b0;
  logic        ewlo = 1'b0;
  logic        erdhilo = 1'b0;
  logic        ecancel = 1'b0;
  logic [31:0] hi, lo;
  logic        busy, stall, done;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  pipemdu #(.WIDTH(32)) dut (
    .clock   (clock),
    .resetn  (resetn),
    .estart  (estart),
    .eop     (eop),
    .ea      (ea),
    .eb      (eb),
    .ewhi    (ewhi),
    .ewlo    (ewlo),
    .erdhilo (erdhilo),
    .ecancel (ecancel),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .stall   (stall),
    .done    (done)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Reference arithmetic: full-width products and truncating division.
  function automatic void modelOp(input logic [1:0] op, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] h,
                                  output logic [31:0] l);
    longint unsigned up;
    longint sp, sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    h = '0;
    l = '0;
    case (op)
      2'b00: begin up = {32'b0, a} * {32'b0, b}; h = up[63:32]; l = up[31:0]; end
      2'b01: begin sp = sa * sb; h = sp[63:32]; l = sp[31:0]; end
      default: begin
        if (b == 32'd0) begin
          h = a;
          l = 32'hFFFF_FFFF;
        end else if (op == 2'b10) begin
          l = a / b;
          h = a % b;
        end else begin
          q = sa / sb;
          r = sa % sb;
          l = q[31:0];
          h = r[31:0];
        end
      end
    endcase
  endfunction

  // Issue one mult/div at edge T0; returns just after T0.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b);
    @(negedge clock);
    eop = op;
    ea = a;
    eb = b;
    estart = 1'b1;
    #1 checkOutput("start_nostall", {63'b0, stall}, 64'd0);
    @(posedge clock);
    #1 estart = 1'b0;
  endtask

  // Count edges after T0 until done is seen; busy must be high until then.
  task automatic waitDone(output int edges, output logic busy_ok);
    edges = 0;
    busy_ok = 1'b1;
    do begin
      @(posedge clock);
      edges++;
      @(negedge clock);
      if (!done && !busy) busy_ok = 1'b0;
    end while (!done && edges < 60);
    if (done && busy) busy_ok = 1'b0;
  endtask

  task automatic runOp(input string tag, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    int edges;
    logic bok;
    int lat;
    modelOp(op, a, b, exp_hi, exp_lo);
    lat = (op[1] && b == 32'd0) ? 1 : 33;
    applyStimulus(op, a, b);
    waitDone(edges, bok);
    checkOutput({tag, "_latency"}, 64'(edges), 64'(lat));
    checkOutput({tag, "_busy"}, {63'b0, bok}, 64'd1);
    checkOutput({tag, "_hilo"}, {hi, lo}, {exp_hi, exp_lo});
  endtask

  initial begin
    int n;
    logic bad, seen;
    logic [1:0] rop;
    logic [31:0] ra, rb;

    #1;
    checkOutput("reset_hilo", {hi, lo}, 64'd0);
    checkOutput("reset_busy_done", {62'b0, busy, done}, 64'd0);
    #20 resetn = 1'b1;

    // MTHI and MTLO together in IDLE.
    @(negedge clock);
    ea = 32'hA5A5_0001; ewhi = 1'b1; ewlo = 1'b1;
    @(posedge clock); #1 ewhi = 1'b0; ewlo = 1'b0;
    exp_hi = 32'hA5A5_0001; exp_lo = 32'hA5A5_0001;
    @(negedge clock);
    checkOutput("mt_both", {hi, lo}, {exp_hi, exp_lo});

    runOp("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checkOutput("multu_max_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    runOp("mult_neg", 2'b01, 32'hFFFF_FFFD, 32'd7);
    checkOutput("mult_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    runOp("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    checkOutput("div_ovf_const", {hi, lo}, 64'h0000_0000_8000_0000);
    runOp("div_neg", 2'b11, 32'hFFFF_FFF9, 32'd2);
    checkOutput("div_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    runOp("divu_100_7", 2'b10, 32'd100, 32'd7);
    checkOutput("divu_100_7_const", {hi, lo}, {32'd2, 32'd14});
    runOp("divu_zero", 2'b10, 32'd100, 32'd0);
    checkOutput("divu_zero_const", {hi, lo}, 64'h0000_0064_FFFF_FFFF);
    runOp("div_zero_neg", 2'b11, 32'hFFFF_FF00, 32'd0);

    // estart together with ecancel in IDLE is ignored.
    @(negedge clock);
    eop = 2'b01; ea = 32'd3; eb = 32'd3; estart = 1'b1; ecancel = 1'b1;
    @(posedge clock); #1 estart = 1'b0; ecancel = 1'b0;
    @(negedge clock);
    checkOutput("cancel_start_busy", {63'b0, busy}, 64'd0);

    // MFHI/MFLO arrives at T5 and is held until the result lands.
    modelOp(2'b01, 32'h1234_5678, 32'hFEDC_BA98, exp_hi, exp_lo);
    applyStimulus(2'b01, 32'h1234_5678, 32'hFEDC_BA98);
    repeat (4) @(posedge clock);
    @(negedge clock);
    erdhilo = 1'b1;
    #1 bad = !stall;
    n = 0;
    do begin
      @(posedge clock);
      @(negedge clock);
      if (!done) begin
        n++;
        if (!stall) bad = 1'b1;
      end
    end while (!done && n < 60);
    checkOutput("rd_stall_held", {63'b0, bad}, 64'd0);
    checkOutput("rd_stall_cycles", 64'(n), 64'd28);
    checkOutput("rd_release", {62'b0, done, stall}, 64'd2);
    checkOutput("rd_hilo", {hi, lo}, {exp_hi, exp_lo});
    erdhilo = 1'b0;

    // MTLO while busy is stalled, then written once the unit is idle.
    modelOp(2'b10, 32'd5000, 32'd3, exp_hi, exp_lo);
    applyStimulus(2'b10, 32'd5000, 32'd3);
    @(negedge clock);
    ea = 32'h1234; ewlo = 1'b1;
    bad = 1'b0;
    n = 0;
    do begin
      #1 if (!done && !stall) bad = 1'b1;
      @(posedge clock);
      n++;
      @(negedge clock);
    end while (!done && n < 60);
    checkOutput("mtlo_stalled", {63'b0, bad}, 64'd0);
    checkOutput("mtlo_release", {62'b0, done, stall}, 64'd2);
    @(posedge clock); #1 ewlo = 1'b0;
    exp_lo = 32'h1234;
    @(negedge clock);
    checkOutput("mtlo_written", {hi, lo}, {exp_hi, exp_lo});

    // ecancel at T10 drops the operation.
    applyStimulus(2'b00, 32'hDEAD_BEEF, 32'h0000_0100);
    repeat (9) @(posedge clock);
    @(negedge clock);
    ecancel = 1'b1;
    @(posedge clock); #1 ecancel = 1'b0;
    @(negedge clock);
    checkOutput("cancel_idle", {63'b0, busy}, 64'd0);
    seen = done;
    repeat (40) begin
      @(negedge clock);
      if (done) seen = 1'b1;
    end
    checkOutput("cancel_nodone", {63'b0, seen}, 64'd0);
    checkOutput("cancel_hilo", {hi, lo}, {exp_hi, exp_lo});

    // Randomized operations, biased toward boundary operands.
    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 15);
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      runOp($sformatf("rand%0d", i), rop, ra, rb);
    end

    // Reset at T20 clears everything immediately.
    applyStimulus(2'b11, 32'h7654_3210, 32'd9);
    repeat (19) @(posedge clock);
    @(negedge clock);
    resetn = 1'b0;
    #1;
    checkOutput("reset_mid_hilo", {hi, lo}, 64'd0);
    checkOutput("reset_mid_busy", {63'b0, busy}, 64'd0);
    #1 resetn = 1'b1;
    exp_hi = '0; exp_lo = '0;
    runOp("after_reset", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
